// File: rtl/wb_master_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_pkg
// Shared definitions for the Wishbone command master:
//   - wb_state_t : master FSM state encoding (IDLE -> BUS -> RSP -> IDLE)
//   - CMD_W      : width of one command FIFO entry {we, adr, dat, sel}
//   - CMD_*      : bit offsets of each field inside a FIFO entry
// -----------------------------------------------------------------------------
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } wb_state_t;

    // Entry layout, MSB first: we(1) | adr(32) | dat(32) | sel(4)
    localparam int CMD_W       = 69;
    localparam int CMD_SEL_LSB = 0;
    localparam int CMD_DAT_LSB = 4;
    localparam int CMD_ADR_LSB = 36;
    localparam int CMD_WE_BIT  = 68;

endpackage

// File: rtl/wb_cmd_fifo.sv
// -----------------------------------------------------------------------------
// wb_cmd_fifo
// Synchronous command FIFO, power-of-two depth, pointers wrap naturally.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push_i        : write request (accepted only while ready_o is high)
//   wr_data_i     : entry to write
//   pop_i         : read request (ignored while empty)
//   rd_data_o     : entry at the head of the FIFO
//   ready_o       : registered "not full"; low during reset, so a push is
//                   refused when full even if a pop happens in the same cycle
//   empty_o       : FIFO holds no entries
// -----------------------------------------------------------------------------
module wb_cmd_fifo
    import wb_master_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             ready_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             push_acc_s;
    logic             pop_acc_s;

    assign push_acc_s = push_i & ready_q;
    assign pop_acc_s  = pop_i & (count_q != {CW{1'b0}});

    // Next-state for storage, pointers, occupancy and the registered ready flag
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_acc_s) begin
            mem_d[wptr_q] = wr_data_i;
            wptr_d        = wptr_q + PW'(1'b1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_acc_s) begin
            rptr_d = rptr_q + PW'(1'b1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_acc_s, pop_acc_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(DEPTH));
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ready_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign ready_o   = ready_q;
    assign empty_o   = (count_q == {CW{1'b0}});

endmodule

// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
// Wishbone classic single-cycle initiator fed by a command FIFO. One
// transaction outstanding at a time; each ends with a one-cycle response.
// Parameters:
//   FIFO_DEPTH     : command FIFO entries (power of two, 2..16)
//   TIMEOUT_CYCLES : BUS cycles before abort (only with WB_MASTER_TIMEOUT_EN)
// Build option:
//   WB_MASTER_TIMEOUT_EN : when defined, a transaction with no ack/err after
//                          TIMEOUT_CYCLES bus cycles ends as an error;
//                          otherwise BUS waits indefinitely.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o   : command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i : command fields
//   rsp_valid_o, rsp_dat_o, rsp_err_o         : one-cycle response
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o : bus outputs
//   wb_dat_i, wb_ack_i, wb_err_i              : bus inputs
// -----------------------------------------------------------------------------
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("wb_cmd_master: FIFO_DEPTH must be a power of two in 2..16");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    wb_state_t      state_q, state_d;
    logic           cyc_q, cyc_d;
    logic           we_q, we_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic [3:0]     sel_q, sel_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [31:0]    rsp_dat_q, rsp_dat_d;
    logic           pop_s;
    logic           fifo_empty_s;
    logic [CMD_W-1:0] fifo_head_s;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]    tmo_cnt_q, tmo_cnt_d;
`endif

    wb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push_i    (cmd_valid_i),
        .wr_data_i ({cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i}),
        .pop_i     (pop_s),
        .rd_data_o (fifo_head_s),
        .ready_o   (cmd_ready_o),
        .empty_o   (fifo_empty_s)
    );

    // FSM next-state and registered bus/response outputs
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = 32'h0000_0000;
        pop_s       = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                    we_d    = fifo_head_s[CMD_WE_BIT];
                    adr_d   = fifo_head_s[CMD_ADR_LSB +: 32];
                    dat_d   = fifo_head_s[CMD_DAT_LSB +: 32];
                    sel_d   = fifo_head_s[CMD_SEL_LSB +: 4];
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_cnt_d = 16'h0000;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // err wins over ack; read data is only returned on a clean read ack
                if (wb_ack_i || wb_err_i) begin
                    state_d     = ST_RSP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = wb_err_i;
                    rsp_dat_d   = (wb_err_i || we_q) ? 32'h0000_0000 : wb_dat_i;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_RSP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'h0001;
                end
`else
                else begin
                    state_d = ST_BUS;
                end
`endif
            end
            ST_RSP: begin
                // Response lasts one cycle; cyc is already low, guaranteeing the idle gap
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the bus and abandons any transaction
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'h0000_0000;
            dat_q       <= 32'h0000_0000;
            sel_q       <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 32'h0000_0000;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule
